// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU: returns {remainder, quotient}, one quotient bit per cycle.
// Latency WIDTH+1 cycles (divide-by-zero: 1); start is ignored while busy, and operands are captured at start.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     dvd_mag, dvs_mag, q_fix, r_fix;
  logic [WIDTH:0]       shifted, trial;

  assign dvd_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The partial remainder is always below the divisor, so it fits in WIDTH bits;
  // the extra bit only exists transiently in the shifted/trial values.
  assign shifted = {r_q, q_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign q_fix   = quo_neg_q ? -q_q : q_q;
  assign r_fix   = rem_neg_q ? -r_q : r_q;

  always_comb begin
    state_d   = state_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    dvs_d     = dvs_q;
    r_d       = r_q;
    q_d       = q_q;
    count_d   = count_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_neg_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rem_neg_d = sign & dividend[WIDTH-1];
          dvs_d     = dvs_mag;
          r_d       = '0;
          count_d   = '0;
          div0_d    = (divisor == '0);
          if (divisor == '0) begin
            // Keep the raw dividend bits; they become the remainder unchanged.
            q_d     = dividend;
            state_d = FIX;
          end else begin
            q_d     = dvd_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          r_d = trial[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = div0_q ? {q_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      dvs_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      dvs_q     <= dvs_d;
      r_q       <= r_d;
      q_q       <= q_d;
      count_q   <= count_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
